// File: rtl/mod_mul_unit_if.sv
// Start/done handshake and operand/result bus for the sequential modular multiplier.
interface mod_mul_unit_if #(
  parameter int k = 192
);
  logic         start;
  logic [k-1:0] x;
  logic [k-1:0] y;
  logic [k-1:0] z;
  logic         done;

  modport master (output start, x, y, input  z, done);
  modport slave  (input  start, x, y, output z, done);
endinterface

// File: rtl/mod_mul_unit.sv
// z = x*y mod m, MSB-first interleaved shift-add-reduce, one multiplier bit per clock.
// Note rst_n is an active-high synchronous reset despite its name.
module mod_mul_unit #(
  parameter int           k    = 192,
  parameter int           logk = 8,
  parameter logic [k-1:0] m    = 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_mul_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [k+1:0] M1 = {2'b00, m};
  localparam logic [k+1:0] M2 = {1'b0, m, 1'b0};

  logic [1:0]    state_q, state_d;
  logic [k-1:0]  xr_q, xr_d;
  logic [k-1:0]  yr_q, yr_d;
  logic [k+1:0]  acc_q, acc_d;
  logic [logk-1:0] cnt_q, cnt_d;
  logic [k-1:0]  z_q, z_d;
  logic          done_q, done_d;

  logic [k+1:0]  addend, t, red;

  // acc < m keeps t < 3m, so one conditional subtract of 2m or m restores the invariant.
  // Out-of-contract operands simply wrap in k+2 bits, which stays deterministic.
  always_comb begin
    addend = xr_q[cnt_q] ? {2'b00, yr_q} : '0;
    t      = (acc_q << 1) + addend;
    if (t >= M2)      red = t - M2;
    else if (t >= M1) red = t - M1;
    else              red = t;
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          xr_d    = bus.x;
          yr_d    = bus.y;
          acc_d   = '0;
          cnt_d   = logk'(k - 1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = red;
        if (cnt_q == '0) begin
          z_d     = red[k-1:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - logk'(1);
        end
      end
      S_DONE: begin
        // start held high here must not retrigger; wait for it to drop first
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign bus.z    = z_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mod_mul_unit.sv
// Scoreboarded bench for mod_mul_unit: directed spec vectors plus random operands vs a wide-arithmetic model.
module tb_mod_mul_unit;
  localparam int           K = 192;
  localparam logic [K-1:0] M = 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF;

  typedef struct {
    logic [K-1:0] z;
    bit           care;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mod_mul_unit_if #(.k(K)) bus ();

  mod_mul_unit #(.k(K), .logk(8), .m(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [K-1:0] ref_mul(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [2*K-1:0] p;
    logic [2*K-1:0] r;
    p = {{K{1'b0}}, a} * {{K{1'b0}}, b};
    r = p % {{K{1'b0}}, M};
    return r[K-1:0];
  endfunction

  function automatic logic [K-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [K-1:0] rnd_operand();
    logic [K-1:0] r;
    r = rnd_word();
    if (r >= M) r = r - M;
    return r;
  endfunction

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest outstanding expectation.
  initial begin : monitor
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && pd !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_done: got z=%h with no operation outstanding", bus.z);
        end else begin
          e = sb.pop_front();
          if (e.care) chk("mon_z", bus.z, e.z);
        end
      end
      pd = bus.done;
    end
  end

  task automatic run_op(input logic [K-1:0] xa, input logic [K-1:0] ya,
                        input logic [K-1:0] lit, input bit use_lit,
                        input bit care, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.x     = xa;
    bus.y     = ya;
    bus.start = 1'b1;
    e.z    = use_lit ? lit : ref_mul(xa, ya);
    e.care = care;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.x = rnd_word();
    bus.y = rnd_word();
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", K'(n), K'(K));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", K'(bus.done), K'(1));
      chk("hold_z", bus.z, e.z);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_fall", K'(bus.done), K'(0));
    if (care) chk("z_kept", bus.z, e.z);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [K-1:0] v;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_z", bus.z, '0);
    chk("reset_done", K'(bus.done), K'(0));
    @(negedge clk);
    rst_n = 1'b0;

    run_op(192'hF7, 192'h0A, 192'h9A6, 1'b1, 1'b1, 0);
    run_op(192'h000000000000000000000000000000010000000000000001,
           192'h000000000000000000000000000000010000000000000001,
           192'h000000000000000100000000000000020000000000000001, 1'b1, 1'b1, 0);
    run_op(M - 192'd1, M - 192'd1, 192'd1, 1'b1, 1'b1, 0);
    run_op(M - 192'd1, 192'd2,
           192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFD, 1'b1, 1'b1, 0);
    v = '0;
    v[K-1] = 1'b1;
    run_op(v, 192'd2, 192'h10000000000000001, 1'b1, 1'b1, 0);
    run_op('0, rnd_operand(), '0, 1'b1, 1'b1, 0);

    // start held past done, then dropped and re-raised
    run_op(192'hF7, 192'h0A, 192'h9A6, 1'b1, 1'b1, 5);
    run_op(rnd_operand(), rnd_operand(), '0, 1'b0, 1'b1, 0);

    // reset in the middle of an operation abandons it
    @(negedge clk);
    bus.x     = rnd_operand();
    bus.y     = rnd_operand();
    bus.start = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_z", bus.z, '0);
    chk("abort_done", K'(bus.done), K'(0));
    @(negedge clk);
    rst_n = 1'b0;
    run_op(192'hF7, 192'h0A, 192'h9A6, 1'b1, 1'b1, 0);

    for (int i = 0; i < 8; i++) run_op(rnd_operand(), rnd_operand(), '0, 1'b0, 1'b1, 0);

    // out-of-contract operands: value is don't-care, but done must still arrive on time
    run_op({K{1'b1}}, {K{1'b1}}, '0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d outstanding want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
